bitstream_buffer_ctrl: RTL and testbench
========================================

BITSTREAM_BUFFER_CTRL -- requirements
Module: bitstream_buffer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default `BITSTR_BUFFER_ADDR_WIDTH (9), giving the word-address width of the buffer RAM (depth 2^ADDR_W = 512).
REQ-002 SHALL have parameter AFULL_THRESH, default 480, giving the fill level at or above which Almost_Full_O asserts.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clock.
REQ-004 SHALL have these ports:
 - clock  in  1  system clock
 - resetn  in  1  asynchronous active-low reset
 - Flush_I  in  1  discard buffer contents
 - Wr_Valid_I  in  1  producer word valid
 - Wr_Data_I  in  32  producer word
 - Wr_Ready_O  out  1  controller accepts a write this cycle
 - Rd_Req_I  in  1  parser requests next word
 - Rd_Valid_O  out  1  Rd_Data_O holds the requested word
 - Rd_Data_O  out  32  word to parser
 - Fill_Level_O  out  ADDR_W+1  words held
 - Empty_O, Full_O, Almost_Full_O  out  1 each  status flags
 - Address_A_O  out  ADDR_W  RAM write address
 - Write_Enable_A_O  out  1  RAM write enable
 - Data_A_O  out  32  RAM write data
 - Enable_B_O  out  1  RAM read enable
 - Address_B_O  out  ADDR_W  RAM read address
 - Data_B_I  in  32  RAM read data (1-cycle synchronous latency)
 - Ovf_Count_O  out  16  dropped-write count

Function
REQ-005 SHALL implement a circular FIFO over the RAM using wr_ptr and rd_ptr, each ADDR_W bits, wrapping from 2^ADDR_W-1 to 0.
REQ-006 SHALL drive Wr_Ready_O = !Full_O && state==RUN, combinationally.
REQ-007 SHALL accept a write when Wr_Valid_I && Wr_Ready_O; in that cycle it SHALL drive Write_Enable_A_O=1, Address_A_O=wr_ptr, and Data_A_O=Wr_Data_I, then increment wr_ptr.
REQ-008 SHALL accept a read when Rd_Req_I && !Empty_O && state==RUN; in that cycle it SHALL drive Enable_B_O=1 and Address_B_O=rd_ptr, then increment rd_ptr.
REQ-009 SHALL assert Rd_Valid_O for exactly one cycle, the cycle after an accepted read; Rd_Data_O SHALL equal Data_B_I in that cycle and 0 otherwise.
REQ-010 SHALL ignore a read request while Empty_O; no RAM access occurs and Rd_Valid_O stays 0.
REQ-011 SHALL update the fill count as: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-012 SHALL set Empty_O = (count==0), Full_O = (count==2^ADDR_W), Almost_Full_O = (count>=AFULL_THRESH), and Fill_Level_O = count, all registered-state derived.
REQ-013 SHALL allow a simultaneous write and read when the buffer is neither empty nor full; an accepted read never targets the address being written.
REQ-014 SHALL have an FSM with states RUN and FLUSH. RUN->FLUSH on Flush_I. FLUSH lasts exactly 2 cycles, then returns to RUN.
REQ-015 On entry to FLUSH it SHALL zero wr_ptr, rd_ptr, and count. No write or read is accepted while in FLUSH. Rd_Valid_O may still assert for a read accepted in the cycle before Flush_I. Flush_I held high SHALL keep the FSM in FLUSH.
REQ-016 SHALL give Flush_I priority over Wr_Valid_I and Rd_Req_I in the same cycle; neither is accepted.

Reset
REQ-017 On resetn=0 it SHALL asynchronously clear: state=RUN, pointers=0, count=0, Rd_Valid_O=0, Ovf_Count_O=0. Outputs SHALL then read Empty_O=1, Full_O=0, Wr_Ready_O=1, and all RAM enables=0.
REQ-018 Reset mid-operation SHALL abandon any in-flight read; Rd_Valid_O SHALL not assert after reset release.

Configuration
REQ-019 With BITSTR_BUFFER_OVF_CNT_EN defined, Ovf_Count_O SHALL count cycles with Wr_Valid_I && Full_O && state==RUN, saturating at 16'hFFFF and cleared by reset or flush.
REQ-020 Without BITSTR_BUFFER_OVF_CNT_EN, Ovf_Count_O SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-021 SHALL place the FSM state encoding (RUN, FLUSH) and the AFULL_THRESH default in defines.v, alongside BITSTR_BUFFER_ADDR_WIDTH.
REQ-022 SHALL be a single module with no sub-modules. It connects to Bitstream_Buffer port A/B signals one-to-one at the parent level.

Verification
REQ-023 Reset, then write 3 words (A0,A1,A2), then read 3 -> Rd_Valid_O one cycle after each accepted request, data A0,A1,A2 in order, Fill_Level_O returns to 0 and Empty_O=1.
REQ-024 Write 512 words -> Full_O=1 and Wr_Ready_O=0; a further write sets Ovf_Count_O=1 (macro on) and stays 0 (macro off); Almost_Full_O rises when Fill_Level_O reaches 480.
REQ-025 At fill 100, issue write and read in the same cycle for 50 cycles -> Fill_Level_O stays 100 and read data order is preserved.
REQ-026 Write 600 and read 600 interleaved -> pointers wrap past 511 to 0 with no data corruption.
REQ-027 Pulse Flush_I at fill 37 with a read accepted the prior cycle -> that Rd_Valid_O still fires, Fill_Level_O=0, Wr_Ready_O=0 for 2 cycles then 1.
REQ-028 Deassert resetn mid-burst with a read pending -> Rd_Valid_O=0, Empty_O=1, and Ovf_Count_O=0 immediately (asynchronously).

Source files
------------

// File: rtl/bitstream_buffer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bitstream_buffer_ctrl_pkg
// Shared definitions for the bitstream buffer controller:
//   - BITSTR_BUFFER_ADDR_WIDTH : default RAM word-address width (9 -> 512 words)
//   - BBC_ADDR_W_DEF           : package view of the default address width
//   - BBC_AFULL_THRESH_DEF     : default almost-full threshold (480 words)
//   - state_e                  : controller FSM encoding (RUN, FLUSH)
// Optional feature macro used elsewhere: BITSTR_BUFFER_OVF_CNT_EN.
// -----------------------------------------------------------------------------
`ifndef BITSTR_BUFFER_ADDR_WIDTH
`define BITSTR_BUFFER_ADDR_WIDTH 9
`endif

package bitstream_buffer_ctrl_pkg;

  localparam int BBC_ADDR_W_DEF       = `BITSTR_BUFFER_ADDR_WIDTH;
  localparam int BBC_AFULL_THRESH_DEF = 480;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/bitstream_buffer_ctrl_if.sv
// -----------------------------------------------------------------------------
// bitstream_buffer_ctrl_if
// Bundles every non-clock/reset signal of the bitstream buffer controller:
//   producer side : Wr_Valid_I, Wr_Data_I, Wr_Ready_O
//   parser side   : Rd_Req_I, Rd_Valid_O, Rd_Data_O
//   control/status: Flush_I, Fill_Level_O, Empty_O, Full_O, Almost_Full_O,
//                   Ovf_Count_O, Dbg_State_O (FSM state, observation only)
//   RAM port A    : Address_A_O, Write_Enable_A_O, Data_A_O
//   RAM port B    : Enable_B_O, Address_B_O, Data_B_I (1-cycle read latency)
// Modports: slave  = the controller itself
//           master = the surrounding environment (producer, parser, RAM)
//
// Handshakes: a write is taken in any cycle where Wr_Valid_I and Wr_Ready_O
// are both high and Flush_I is low. A read is taken in any cycle where
// Rd_Req_I is high, the buffer is not empty, the FSM is in RUN and Flush_I is
// low; the word appears on Rd_Data_O with Rd_Valid_O exactly one cycle later.
// -----------------------------------------------------------------------------
interface bitstream_buffer_ctrl_if
  import bitstream_buffer_ctrl_pkg::*;
#(
  parameter int ADDR_W = BBC_ADDR_W_DEF
);
  logic              Flush_I;
  logic              Wr_Valid_I;
  logic [31:0]       Wr_Data_I;
  logic              Wr_Ready_O;
  logic              Rd_Req_I;
  logic              Rd_Valid_O;
  logic [31:0]       Rd_Data_O;
  logic [ADDR_W:0]   Fill_Level_O;
  logic              Empty_O;
  logic              Full_O;
  logic              Almost_Full_O;
  logic [ADDR_W-1:0] Address_A_O;
  logic              Write_Enable_A_O;
  logic [31:0]       Data_A_O;
  logic              Enable_B_O;
  logic [ADDR_W-1:0] Address_B_O;
  logic [31:0]       Data_B_I;
  logic [15:0]       Ovf_Count_O;
  state_e            Dbg_State_O;

  modport slave (
    input  Flush_I, Wr_Valid_I, Wr_Data_I, Rd_Req_I, Data_B_I,
    output Wr_Ready_O, Rd_Valid_O, Rd_Data_O, Fill_Level_O, Empty_O, Full_O,
           Almost_Full_O, Address_A_O, Write_Enable_A_O, Data_A_O,
           Enable_B_O, Address_B_O, Ovf_Count_O, Dbg_State_O
  );

  modport master (
    output Flush_I, Wr_Valid_I, Wr_Data_I, Rd_Req_I, Data_B_I,
    input  Wr_Ready_O, Rd_Valid_O, Rd_Data_O, Fill_Level_O, Empty_O, Full_O,
           Almost_Full_O, Address_A_O, Write_Enable_A_O, Data_A_O,
           Enable_B_O, Address_B_O, Ovf_Count_O, Dbg_State_O
  );

endinterface

// File: rtl/bitstream_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// bitstream_buffer_ctrl
// Circular-FIFO controller in front of an external dual-port buffer RAM
// (port A write, port B synchronous read with 1-cycle latency). The producer
// pushes 32-bit words, the parser pulls them one at a time. Flush_I discards
// everything and holds the controller in FLUSH for two cycles.
//
// Ports:
//   clock  : system clock, all state on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : bitstream_buffer_ctrl_if.slave (producer, parser, status, RAM A/B)
//
// Parameters:
//   ADDR_W       : RAM word-address width, depth = 2**ADDR_W
//   AFULL_THRESH : fill level at or above which Almost_Full_O is set
//
// Build option: define BITSTR_BUFFER_OVF_CNT_EN to count cycles in which the
// producer offers a word while the buffer is full (saturating, 16 bits).
// Without it Ovf_Count_O is tied to zero.
// -----------------------------------------------------------------------------
module bitstream_buffer_ctrl
  import bitstream_buffer_ctrl_pkg::*;
#(
  parameter int ADDR_W       = BBC_ADDR_W_DEF,
  parameter int AFULL_THRESH = BBC_AFULL_THRESH_DEF
) (
  input logic                   clock,
  input logic                   resetn,
  bitstream_buffer_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W + 1)'(AFULL_THRESH);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_flush_cyc;
  logic              w_flush_cyc_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_rd_valid;

  logic w_run;
  logic w_empty;
  logic w_full;
  logic w_wr_ready;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_run      = (r_state == ST_RUN);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_wr_ready = !w_full && w_run;

  // Flush_I wins over both handshakes in the same cycle. Wr_Ready_O itself
  // only reflects fullness and FSM state, so a producer seeing ready during
  // a Flush_I cycle must still treat the word as not taken.
  assign w_wr_acc = bus.Wr_Valid_I && w_wr_ready && !bus.Flush_I;
  assign w_rd_acc = bus.Rd_Req_I && !w_empty && w_run && !bus.Flush_I;

  // ---------------------------------------------------------------------------
  // FSM: RUN <-> FLUSH. r_flush_cyc counts the two FLUSH cycles after Flush_I
  // drops; Flush_I held high keeps restarting that count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_RUN;
      r_flush_cyc <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cyc <= w_flush_cyc_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cyc_nxt = r_flush_cyc;
    case (r_state)
      ST_RUN: begin
        if (bus.Flush_I) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cyc_nxt = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (bus.Flush_I) begin
          w_flush_cyc_nxt = 1'b0;
        end else if (r_flush_cyc) begin
          w_state_nxt     = ST_RUN;
          w_flush_cyc_nxt = 1'b0;
        end else begin
          w_flush_cyc_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_flush_cyc_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers and fill count. Pointers wrap naturally at 2**ADDR_W. A read is
  // only taken when count > 0 and a write only when count < depth, so with
  // both in one cycle rd_ptr != wr_ptr and the RAM never sees a same-address
  // read/write collision.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      // A read taken last cycle still returns its word during the flush.
      r_rd_valid <= w_rd_acc;
      if (bus.Flush_I) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_wr_acc, w_rd_acc})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow counter (optional)
  // ---------------------------------------------------------------------------
`ifdef BITSTR_BUFFER_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ovf_cnt <= '0;
    end else if (bus.Flush_I) begin
      r_ovf_cnt <= '0;
    end else if (bus.Wr_Valid_I && w_full && w_run && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign bus.Ovf_Count_O = r_ovf_cnt;
`else
  assign bus.Ovf_Count_O = 16'h0000;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.Wr_Ready_O       = w_wr_ready;
  assign bus.Write_Enable_A_O = w_wr_acc;
  assign bus.Address_A_O      = r_wr_ptr;
  assign bus.Data_A_O         = bus.Wr_Data_I;
  assign bus.Enable_B_O       = w_rd_acc;
  assign bus.Address_B_O      = r_rd_ptr;
  assign bus.Rd_Valid_O       = r_rd_valid;
  assign bus.Rd_Data_O        = r_rd_valid ? bus.Data_B_I : 32'h0;
  assign bus.Fill_Level_O     = r_count;
  assign bus.Empty_O          = w_empty;
  assign bus.Full_O           = w_full;
  assign bus.Almost_Full_O    = (r_count >= AFULL_CNT);
  assign bus.Dbg_State_O      = r_state;

endmodule

// File: tb/tb_bitstream_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bitstream_buffer_ctrl
// Directed bench for bitstream_buffer_ctrl. A behavioural 512x32 RAM with a
// one-cycle synchronous read sits on port A/B. The bench keeps its own FIFO
// model (expected queue, fill level, flush cycles left) and each test task
// compares DUT outputs against it or against hand-computed constants.
// Inputs are driven on the falling edge; outputs are sampled 1 ns after the
// rising edge (registered state) or 1 ns after the falling edge (combinational
// enables for the cycle being driven).
// -----------------------------------------------------------------------------
module tb_bitstream_buffer_ctrl;
  import bitstream_buffer_ctrl_pkg::*;

  localparam int AW = 9;

  logic clk;
  logic rst_n;

  bitstream_buffer_ctrl_if #(.ADDR_W(AW)) bus ();

  bitstream_buffer_ctrl #(.ADDR_W(AW), .AFULL_THRESH(480)) dut (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [31:0] ram [0:(1<<AW)-1];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (bus.Write_Enable_A_O) ram[bus.Address_A_O] <= bus.Data_A_O;
    if (bus.Enable_B_O)       ram_q <= ram[bus.Address_B_O];
  end
  assign bus.Data_B_I = ram_q;

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];
  int          exp_fill;
  int          flush_left;
  int          n_tests;
  int          n_fail;
  logic [15:0] exp_ovf_one;

  logic        rd_acc;
  logic [31:0] rd_exp;
  logic        seen_we;
  logic        seen_en_b;

  // ---------------- driver ----------------
  // Drives one cycle, advances the bench model, and returns what the model
  // says about the read plus the enables seen during that cycle.
  task automatic xfer(input logic wv, input logic [31:0] wd, input logic rr,
                      input logic fl, output logic o_rd_acc,
                      output logic [31:0] o_rd_exp, output logic o_we,
                      output logic o_en_b);
    bit run;
    bit w_ok;
    @(negedge clk);
    bus.Wr_Valid_I = wv;
    bus.Wr_Data_I  = wd;
    bus.Rd_Req_I   = rr;
    bus.Flush_I    = fl;
    #1;
    o_we   = bus.Write_Enable_A_O;
    o_en_b = bus.Enable_B_O;
    run      = (flush_left == 0);
    w_ok     = wv && run && !fl && (exp_fill < 512);
    o_rd_acc = rr && run && !fl && (exp_fill > 0);
    o_rd_exp = 32'h0;
    if (o_rd_acc) o_rd_exp = exp_q.pop_front();
    if (w_ok) exp_q.push_back(wd);
    exp_fill = exp_fill + (w_ok ? 1 : 0) - (o_rd_acc ? 1 : 0);
    if (fl) begin
      exp_q.delete();
      exp_fill   = 0;
      flush_left = 2;
    end else if (flush_left > 0) begin
      flush_left--;
    end
    @(posedge clk);
    #1;
    bus.Wr_Valid_I = 1'b0;
    bus.Rd_Req_I   = 1'b0;
    bus.Flush_I    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.Wr_Valid_I = 1'b0; bus.Wr_Data_I = 32'h0; bus.Rd_Req_I = 1'b0; bus.Flush_I = 1'b0;
    exp_q.delete(); exp_fill = 0; flush_left = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.Empty_O !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b want=1", bus.Empty_O); end
    n_tests++; if (bus.Full_O !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b want=0", bus.Full_O); end
    n_tests++; if (bus.Wr_Ready_O !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got=%b want=1", bus.Wr_Ready_O); end
    n_tests++; if (bus.Fill_Level_O !== 10'd0) begin n_fail++; $display("FAIL reset_fill got=%0d want=0", bus.Fill_Level_O); end
    n_tests++; if ({bus.Write_Enable_A_O, bus.Enable_B_O} !== 2'b00) begin n_fail++; $display("FAIL reset_ram_en got=%b want=00", {bus.Write_Enable_A_O, bus.Enable_B_O}); end
    n_tests++; if (bus.Rd_Valid_O !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b want=0", bus.Rd_Valid_O); end
    n_tests++; if (bus.Ovf_Count_O !== 16'd0) begin n_fail++; $display("FAIL reset_ovf got=%0d want=0", bus.Ovf_Count_O); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) xfer(1'b1, 32'hA0 + i, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    n_tests++; if (bus.Fill_Level_O !== 10'd3) begin n_fail++; $display("FAIL basic_fill3 got=%0d want=3", bus.Fill_Level_O); end
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 32'h0, 1'b1, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
      n_tests++; if (bus.Rd_Valid_O !== 1'b1) begin n_fail++; $display("FAIL basic_rd_valid[%0d] got=%b want=1", i, bus.Rd_Valid_O); end
      n_tests++; if (bus.Rd_Data_O !== 32'hA0 + i) begin n_fail++; $display("FAIL basic_rd_data[%0d] got=%h want=%h", i, bus.Rd_Data_O, 32'hA0 + i); end
    end
    xfer(1'b0, 32'h0, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    n_tests++; if (bus.Rd_Valid_O !== 1'b0 || bus.Rd_Data_O !== 32'h0) begin n_fail++; $display("FAIL basic_rd_one_cycle got=%b/%h want=0/0", bus.Rd_Valid_O, bus.Rd_Data_O); end
    n_tests++; if (bus.Fill_Level_O !== 10'd0 || bus.Empty_O !== 1'b1) begin n_fail++; $display("FAIL basic_drained got=%0d/%b want=0/1", bus.Fill_Level_O, bus.Empty_O); end
  endtask

  task automatic test_empty_read();
    xfer(1'b0, 32'h0, 1'b1, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    n_tests++; if (seen_en_b !== 1'b0) begin n_fail++; $display("FAIL empty_rd_en_b got=%b want=0", seen_en_b); end
    n_tests++; if (bus.Rd_Valid_O !== 1'b0) begin n_fail++; $display("FAIL empty_rd_valid got=%b want=0", bus.Rd_Valid_O); end
  endtask

  task automatic test_full();
    for (int k = 1; k <= 512; k++) begin
      xfer(1'b1, 32'h1000_0000 + k, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
      if (k == 479) begin
        n_tests++; if (bus.Almost_Full_O !== 1'b0) begin n_fail++; $display("FAIL afull_479 got=%b want=0", bus.Almost_Full_O); end
      end
      if (k == 480) begin
        n_tests++; if (bus.Almost_Full_O !== 1'b1 || bus.Fill_Level_O !== 10'd480) begin n_fail++; $display("FAIL afull_480 got=%b/%0d want=1/480", bus.Almost_Full_O, bus.Fill_Level_O); end
      end
    end
    n_tests++; if (bus.Full_O !== 1'b1 || bus.Wr_Ready_O !== 1'b0) begin n_fail++; $display("FAIL full_flags got=%b/%b want=1/0", bus.Full_O, bus.Wr_Ready_O); end
    xfer(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    n_tests++; if (seen_we !== 1'b0) begin n_fail++; $display("FAIL full_no_write got=%b want=0", seen_we); end
    n_tests++; if (bus.Fill_Level_O !== 10'd512) begin n_fail++; $display("FAIL full_fill got=%0d want=512", bus.Fill_Level_O); end
    n_tests++; if (bus.Ovf_Count_O !== exp_ovf_one) begin n_fail++; $display("FAIL full_ovf got=%0d want=%0d", bus.Ovf_Count_O, exp_ovf_one); end
    xfer(1'b0, 32'h0, 1'b0, 1'b1, rd_acc, rd_exp, seen_we, seen_en_b);
    repeat (2) xfer(1'b0, 32'h0, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    n_tests++; if (bus.Fill_Level_O !== 10'd0 || bus.Ovf_Count_O !== 16'd0 || bus.Empty_O !== 1'b1) begin n_fail++; $display("FAIL full_flush_clear got=%0d/%0d/%b want=0/0/1", bus.Fill_Level_O, bus.Ovf_Count_O, bus.Empty_O); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 100; i++) xfer(1'b1, 32'h2000_0000 + i, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    for (int i = 0; i < 50; i++) begin
      xfer(1'b1, 32'h3000_0000 + i, 1'b1, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
      n_tests++; if (bus.Rd_Valid_O !== 1'b1 || bus.Rd_Data_O !== rd_exp) begin n_fail++; $display("FAIL b2b_rd[%0d] got=%b/%h want=1/%h", i, bus.Rd_Valid_O, bus.Rd_Data_O, rd_exp); end
    end
    n_tests++; if (bus.Fill_Level_O !== 10'd100) begin n_fail++; $display("FAIL b2b_fill got=%0d want=100", bus.Fill_Level_O); end
    for (int i = 0; i < 100; i++) begin
      xfer(1'b0, 32'h0, 1'b1, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
      n_tests++; if (bus.Rd_Valid_O !== 1'b1 || bus.Rd_Data_O !== rd_exp) begin n_fail++; $display("FAIL b2b_drain[%0d] got=%b/%h want=1/%h", i, bus.Rd_Valid_O, bus.Rd_Data_O, rd_exp); end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 604; i++) begin
      xfer(i < 600, 32'h5000_0000 + i, i >= 4, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
      if (rd_acc) begin
        n_tests++; if (bus.Rd_Valid_O !== 1'b1 || bus.Rd_Data_O !== rd_exp) begin n_fail++; $display("FAIL wrap_rd[%0d] got=%b/%h want=1/%h", i, bus.Rd_Valid_O, bus.Rd_Data_O, rd_exp); end
      end
    end
    n_tests++; if (bus.Fill_Level_O !== 10'd0 || bus.Empty_O !== 1'b1) begin n_fail++; $display("FAIL wrap_end got=%0d/%b want=0/1", bus.Fill_Level_O, bus.Empty_O); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 38; i++) xfer(1'b1, 32'h6000_0000 + i, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    xfer(1'b0, 32'h0, 1'b1, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    n_tests++; if (bus.Fill_Level_O !== 10'd37) begin n_fail++; $display("FAIL flush_fill37 got=%0d want=37", bus.Fill_Level_O); end
    n_tests++; if (bus.Rd_Valid_O !== 1'b1 || bus.Rd_Data_O !== 32'h6000_0000) begin n_fail++; $display("FAIL flush_prior_rd got=%b/%h want=1/60000000", bus.Rd_Valid_O, bus.Rd_Data_O); end
    xfer(1'b1, 32'hBAD0_0001, 1'b1, 1'b1, rd_acc, rd_exp, seen_we, seen_en_b);
    n_tests++; if ({seen_we, seen_en_b} !== 2'b00) begin n_fail++; $display("FAIL flush_priority got=%b want=00", {seen_we, seen_en_b}); end
    n_tests++; if (bus.Fill_Level_O !== 10'd0 || bus.Empty_O !== 1'b1 || bus.Rd_Valid_O !== 1'b0) begin n_fail++; $display("FAIL flush_clear got=%0d/%b/%b want=0/1/0", bus.Fill_Level_O, bus.Empty_O, bus.Rd_Valid_O); end
    n_tests++; if (bus.Wr_Ready_O !== 1'b0) begin n_fail++; $display("FAIL flush_ready_c1 got=%b want=0", bus.Wr_Ready_O); end
    xfer(1'b1, 32'hBAD0_0002, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    n_tests++; if (seen_we !== 1'b0) begin n_fail++; $display("FAIL flush_no_write got=%b want=0", seen_we); end
    n_tests++; if (bus.Wr_Ready_O !== 1'b0) begin n_fail++; $display("FAIL flush_ready_c2 got=%b want=0", bus.Wr_Ready_O); end
    xfer(1'b0, 32'h0, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    n_tests++; if (bus.Wr_Ready_O !== 1'b1) begin n_fail++; $display("FAIL flush_ready_back got=%b want=1", bus.Wr_Ready_O); end
    xfer(1'b1, 32'h7000_0000, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    n_tests++; if (seen_we !== 1'b1 || bus.Fill_Level_O !== 10'd1) begin n_fail++; $display("FAIL flush_resume got=%b/%0d want=1/1", seen_we, bus.Fill_Level_O); end
  endtask

  task automatic test_reset_mid();
    while (exp_fill < 512) xfer(1'b1, 32'h8000_0000 + exp_fill, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    xfer(1'b1, 32'hBAD0_0003, 1'b0, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    n_tests++; if (bus.Ovf_Count_O !== exp_ovf_one) begin n_fail++; $display("FAIL rstmid_ovf_pre got=%0d want=%0d", bus.Ovf_Count_O, exp_ovf_one); end
    xfer(1'b1, 32'h9000_0000, 1'b1, 1'b0, rd_acc, rd_exp, seen_we, seen_en_b);
    rst_n = 1'b0;
    #1;
    exp_q.delete(); exp_fill = 0; flush_left = 0;
    n_tests++; if (bus.Rd_Valid_O !== 1'b0 || bus.Rd_Data_O !== 32'h0) begin n_fail++; $display("FAIL rstmid_rd_valid got=%b/%h want=0/0", bus.Rd_Valid_O, bus.Rd_Data_O); end
    n_tests++; if (bus.Empty_O !== 1'b1 || bus.Fill_Level_O !== 10'd0) begin n_fail++; $display("FAIL rstmid_empty got=%b/%0d want=1/0", bus.Empty_O, bus.Fill_Level_O); end
    n_tests++; if (bus.Ovf_Count_O !== 16'd0) begin n_fail++; $display("FAIL rstmid_ovf got=%0d want=0", bus.Ovf_Count_O); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (bus.Rd_Valid_O !== 1'b0 || bus.Wr_Ready_O !== 1'b1) begin n_fail++; $display("FAIL rstmid_after got=%b/%b want=0/1", bus.Rd_Valid_O, bus.Wr_Ready_O); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
`ifdef BITSTR_BUFFER_OVF_CNT_EN
    exp_ovf_one = 16'd1;
`else
    exp_ovf_one = 16'd0;
`endif
    test_reset();
    test_basic();
    test_empty_read();
    test_full();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
